// File: rtl/alu_word_sequencer.sv
// Drives a WIDTH-bit combinational ALU one word per cycle to execute an
// operation on WIDTH*WORDS-bit operands, assembling the wide result and NZCV.
module alu_word_sequencer #(
    parameter int WIDTH = 3,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [WIDTH*WORDS-1:0]   opa,
    input  logic [WIDTH*WORDS-1:0]   opb,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_control,
    output logic                     alu_carryin,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_n,
    input  logic                     alu_z,
    input  logic                     alu_c,
    input  logic                     alu_v,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH*WORDS-1:0]   res,
    output logic                     n,
    output logic                     z,
    output logic                     c,
    output logic                     v
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_SRL = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [2:0]           op_q, op_d;
    logic [TOTAL-1:0]     opa_q, opa_d;
    logic [TOTAL-1:0]     opb_q, opb_d;
    logic                 carry_q, carry_d;
    logic                 z_acc_q, z_acc_d;
    logic                 err_q, err_d;
    logic [TOTAL-1:0]     res_q, res_d;
    logic                 n_q, n_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic                 v_q, v_d;

    logic [WIDTH-1:0]     word_a;
    logic [WIDTH-1:0]     word_b;
    logic                 is_arith;
    logic                 first_word;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        carry_d     = carry_q;
        z_acc_d     = z_acc_q;
        err_d       = err_q;
        res_d       = res_q;
        n_d         = n_q;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        alu_carryin = 1'b0;

        word_a     = opa_q[int'(idx_q)*WIDTH +: WIDTH];
        word_b     = opb_q[int'(idx_q)*WIDTH +: WIDTH];
        is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
        first_word = (idx_q == '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                    idx_d   = '0;
                    z_acc_d = 1'b1;
                    carry_d = 1'b0;
                    // Shifts cannot be chained across words here; report and keep res.
                    if ((op == OP_SLL) || (op == OP_SRL)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                alu_a = word_a;
                case (op_q)
                    OP_ADD: begin
                        alu_b       = word_b;
                        alu_carryin = first_word ? 1'b0 : carry_q;
                    end
                    OP_SUB: begin
                        // a - b as a + ~b + 1 so the carry chains like an add
                        alu_b       = ~word_b;
                        alu_carryin = first_word ? 1'b1 : carry_q;
                    end
                    default: begin
                        alu_control = op_q;
                        alu_b       = word_b;
                    end
                endcase

                res_d[int'(idx_q)*WIDTH +: WIDTH] = alu_result;
                carry_d = alu_c;
                z_acc_d = z_acc_q & alu_z;
                idx_d   = idx_q + 1'b1;

                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                    n_d     = alu_n;
                    z_d     = z_acc_q & alu_z;
                    c_d     = is_arith & alu_c;
                    v_d     = is_arith & alu_v;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            z_acc_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            z_acc_q <= z_acc_d;
            err_q   <= err_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);
    assign err  = err_q;
    assign res  = res_q;
    assign n    = n_q;
    assign z    = z_q;
    assign c    = c_q;
    assign v    = v_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer with a 3-bit behavioural ALU; expected results
// are queued when an op is launched and checked when done pulses.
module tb_alu_word_sequencer;

    localparam int WIDTH = 3;
    localparam int WORDS = 4;
    localparam int TOT   = WIDTH * WORDS;

    typedef struct packed {
        logic [TOT-1:0] res;
        logic           n;
        logic           z;
        logic           c;
        logic           v;
        logic           err;
    } exp_t;

    typedef struct {
        logic [2:0]     op;
        logic [TOT-1:0] a;
        logic [TOT-1:0] b;
        exp_t           e;
        int             lat;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op_i;
    logic [TOT-1:0]   opa_i;
    logic [TOT-1:0]   opb_i;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic             alu_carryin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;
    logic             busy;
    logic             done;
    logic             err;
    logic [TOT-1:0]   res;
    logic             n;
    logic             z;
    logic             c;
    logic             v;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t last;
    vec_t vecs[11];
    logic [WIDTH:0] alu_s;

    alu_word_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op_i),
        .opa         (opa_i),
        .opb         (opb_i),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_carryin (alu_carryin),
        .alu_result  (alu_result),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .res         (res),
        .n           (n),
        .z           (z),
        .c           (c),
        .v           (v)
    );

    always #5 clk = ~clk;

    // Behavioural narrow ALU
    always_comb begin
        alu_s      = '0;
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_control)
            3'd0: begin
                alu_s      = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_carryin};
                alu_result = alu_s[WIDTH-1:0];
                alu_c      = alu_s[WIDTH];
                alu_v      = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_s[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'd1: alu_result = alu_a << 1;
            3'd2: alu_result = alu_a >> 1;
            3'd3: alu_result = alu_a ^ alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: alu_result = alu_a & alu_b;
            default: begin
                alu_s      = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = alu_s[WIDTH-1:0];
                alu_c      = ~alu_s[WIDTH];
            end
        endcase
        alu_n = alu_result[WIDTH-1];
        alu_z = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=1 want=0 at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("res",  32'(res),  32'(mon_e.res));
                chk("n",    32'(n),    32'(mon_e.n));
                chk("z",    32'(z),    32'(mon_e.z));
                chk("c",    32'(c),    32'(mon_e.c));
                chk("v",    32'(v),    32'(mon_e.v));
                chk("err",  32'(err),  32'(mon_e.err));
                chk("busy_in_fin", 32'(busy), 32'd0);
            end
        end
    end

    function automatic exp_t model(input logic [2:0] o, input logic [TOT-1:0] a,
                                   input logic [TOT-1:0] b, input exp_t prev);
        exp_t       e;
        logic [TOT:0] s;
        e = '0;
        s = '0;
        if (o == 3'd1 || o == 3'd2) begin
            e     = prev;
            e.err = 1'b1;
            return e;
        end
        case (o)
            3'd0: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[TOT-1:0];
                e.c   = s[TOT];
                e.v   = (a[TOT-1] == b[TOT-1]) && (e.res[TOT-1] != a[TOT-1]);
            end
            3'd7: begin
                s     = {1'b0, a} + {1'b0, ~b} + 1;
                e.res = s[TOT-1:0];
                e.c   = s[TOT];
                e.v   = (a[TOT-1] != b[TOT-1]) && (e.res[TOT-1] != a[TOT-1]);
            end
            3'd3: e.res = a ^ b;
            3'd4: e.res = a | b;
            3'd5: e.res = ~a;
            default: e.res = a & b;
        endcase
        e.n   = e.res[TOT-1];
        e.z   = (e.res == '0);
        e.err = 1'b0;
        return e;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                         input exp_t e, input int exp_lat);
        int lat;
        sb.push_back(e);
        @(negedge clk);
        op_i  = o;
        opa_i = a;
        opb_i = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [TOT-1:0] r, input logic nn, input logic zz,
                                input logic cc, input logic vv, input logic ee);
        exp_t e;
        e.res = r; e.n = nn; e.z = zz; e.c = cc; e.v = vv; e.err = ee;
        return e;
    endfunction

    initial begin
        int   cnt;
        int   dones;
        int   lat;
        exp_t e;
        logic [2:0]     ro;
        logic [TOT-1:0] ra;
        logic [TOT-1:0] rb;

        vecs[0]  = '{3'd0, 12'hFFF, 12'h001, mk(12'h000, 0, 1, 1, 0, 0), 5};
        vecs[1]  = '{3'd0, 12'h7FF, 12'h001, mk(12'h800, 1, 0, 0, 1, 0), 5};
        vecs[2]  = '{3'd7, 12'h000, 12'h001, mk(12'hFFF, 1, 0, 0, 0, 0), 5};
        vecs[3]  = '{3'd7, 12'h5A5, 12'h5A5, mk(12'h000, 0, 1, 1, 0, 0), 5};
        vecs[4]  = '{3'd3, 12'hA5A, 12'hFFF, mk(12'h5A5, 0, 0, 0, 0, 0), 5};
        vecs[5]  = '{3'd5, 12'h0F0, 12'h000, mk(12'hF0F, 1, 0, 0, 0, 0), 5};
        vecs[6]  = '{3'd6, 12'hA5A, 12'h0F0, mk(12'h050, 0, 0, 0, 0, 0), 5};
        vecs[7]  = '{3'd4, 12'h123, 12'h000, mk(12'h123, 0, 0, 0, 0, 0), 5};
        vecs[8]  = '{3'd1, 12'h123, 12'h001, mk(12'h123, 0, 0, 0, 0, 1), 1};
        vecs[9]  = '{3'd2, 12'h000, 12'h000, mk(12'h123, 0, 0, 0, 0, 1), 1};
        vecs[10] = '{3'd0, 12'h800, 12'h800, mk(12'h000, 0, 1, 1, 1, 0), 5};

        reset = 1'b1;
        start = 1'b0;
        op_i  = '0;
        opa_i = '0;
        opb_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err",  32'(err),  0);
        chk("rst_res",  32'(res),  0);
        chk("rst_nzcv", 32'({n, z, c, v}), 0);
        chk("rst_alu",  32'({alu_a, alu_b, alu_control, alu_carryin}), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat);
        end

        // start pulses while busy and in FIN must not launch anything
        sb.push_back(mk(12'h010, 0, 0, 0, 0, 0));
        @(negedge clk);
        op_i = 3'd0; opa_i = 12'h00F; opb_i = 12'h001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk); start = 1'b1; op_i = 3'd3; opa_i = 12'hFFF;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("pulse_done", 32'(done), 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk);
            #1 dones += int'(done);
        end
        chk("extra_done", 32'(dones), 0);

        // start held high: next op accepted in the IDLE cycle after FIN
        sb.push_back(mk(12'h002, 0, 0, 0, 0, 0));
        sb.push_back(mk(12'h004, 0, 0, 0, 0, 0));
        @(negedge clk);
        op_i = 3'd0; opa_i = 12'h001; opb_i = 12'h001; start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("b2b_first_lat", 32'(lat), 5);
        opa_i = 12'h003;
        lat = 0;
        @(posedge clk);
        #1 lat++;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("b2b_period", 32'(lat), 6);
        start = 1'b0;
        @(negedge clk);

        // reset in the second RUN cycle aborts without a done pulse
        @(negedge clk);
        op_i = 3'd0; opa_i = 12'h001; opb_i = 12'h001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_res",  32'(res),  0);
        chk("abort_nzcv", 32'({n, z, c, v}), 0);
        chk("abort_alu",  32'({alu_a, alu_b, alu_control, alu_carryin}), 0);
        reset = 1'b0;
        dones = 0;
        repeat (6) begin
            @(posedge clk);
            #1 dones += int'(done);
        end
        chk("abort_no_done", 32'(dones), 0);
        do_op(3'd0, 12'h001, 12'h002, mk(12'h003, 0, 0, 0, 0, 0), 5);

        last = mk(12'h003, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 12'($urandom);
            rb = 12'($urandom);
            e  = model(ro, ra, rb, last);
            do_op(ro, ra, rb, e, (ro == 3'd1 || ro == 3'd2) ? 1 : 5);
            last = e;
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
